// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC register, asynchronous-read instruction memory
// with a synchronous write port, and the IF/ID pipeline register.
module if_fetch_unit #(
  parameter int              ADDR_W     = 32,
  parameter int              INS_W      = 32,
  parameter int              IMEM_DEPTH = 256,
  parameter longint unsigned RESET_PC   = 0,
  parameter int              PC_STEP    = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              STALL,
  input  logic              FLUSH,
  input  logic              BRANCH_TAKEN,
  input  logic [ADDR_W-1:0] BRANCH_TARGET,
  input  logic              JUMP_TAKEN,
  input  logic [ADDR_W-1:0] JUMP_TARGET,
  input  logic              MEM_WRITE,
  input  logic [ADDR_W-1:0] WR_ADR,
  input  logic [INS_W-1:0]  WR_DATA,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic [ADDR_W-1:0] NEXT_INS_ADR,
  output logic [INS_W-1:0]  CUR_INS,
  output logic [ADDR_W-1:0] IF_ID_PC4,
  output logic [INS_W-1:0]  IF_ID_INS,
  output logic              IF_ID_VALID,
  output logic              ADR_ERR
);

  localparam int IDX_W = $clog2(IMEM_DEPTH);

  logic [INS_W-1:0]  mem_q [IMEM_DEPTH];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] pc_seq;
  logic              pc_ok;
  logic              redirect;

  // Word-aligned and below 4*IMEM_DEPTH: every bit above the word index must be zero.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> (IDX_W + 2)) == '0);
  endfunction

  assign pc_ok    = addr_ok(pc_q);
  assign pc_seq   = pc_q + ADDR_W'(PC_STEP);
  assign redirect = BRANCH_TAKEN | JUMP_TAKEN;
  assign CUR_INS  = pc_ok ? mem_q[pc_q[IDX_W+1:2]] : '0;

  always_comb begin
    pc_d  = pc_seq;
    pc4_d = pc4_q;
    ins_d = ins_q;
    vld_d = vld_q;
    err_d = err_q;
    if (BRANCH_TAKEN)    pc_d = BRANCH_TARGET;
    else if (JUMP_TAKEN) pc_d = JUMP_TARGET;
    else if (STALL)      pc_d = pc_q;

    // Squash keeps PC4 so a later consumer still sees the last real return address.
    if (FLUSH || redirect) begin
      ins_d = '0;
      vld_d = 1'b0;
      err_d = 1'b0;
    end else if (!STALL) begin
      ins_d = CUR_INS;
      pc4_d = pc_seq;
      vld_d = 1'b1;
      err_d = !pc_ok;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q  <= ADDR_W'(RESET_PC);
      pc4_q <= '0;
      ins_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      pc4_q <= pc4_d;
      ins_q <= ins_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end

  // Memory is deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (MEM_WRITE && addr_ok(WR_ADR))
      mem_q[WR_ADR[IDX_W+1:2]] <= WR_DATA;
  end

  assign PC_OUT       = pc_q;
  assign NEXT_INS_ADR = pc_d;
  assign IF_ID_PC4    = pc4_q;
  assign IF_ID_INS    = ins_q;
  assign IF_ID_VALID  = vld_q;
  assign ADR_ERR      = err_q;

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and address width.
REQ-002 SHALL have parameter INS_W, default 32, instruction word width.
REQ-003 SHALL have parameter IMEM_DEPTH, default 256, instruction memory depth in words (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-005 SHALL have parameter PC_STEP, default 4, sequential PC increment in bytes.
REQ-006 SHALL have one clock and an asynchronous active-high reset, as the ports below.
REQ-007 CLK  input  1  rising-edge clock.
REQ-008 RESET  input  1  asynchronous active-high reset.
REQ-009 STALL  input  1  hold PC and IF/ID register.
REQ-010 FLUSH  input  1  squash IF/ID contents.
REQ-011 BRANCH_TAKEN  input  1  branch redirect request.
REQ-012 BRANCH_TARGET  input  ADDR_W  branch target address.
REQ-013 JUMP_TAKEN  input  1  jump redirect request.
REQ-014 JUMP_TARGET  input  ADDR_W  jump target address.
REQ-015 MEM_WRITE  input  1  instruction memory write enable.
REQ-016 WR_ADR  input  ADDR_W  byte address of write.
REQ-017 WR_DATA  input  INS_W  word to write.
REQ-018 PC_OUT  output  ADDR_W  current PC.
REQ-019 NEXT_INS_ADR  output  ADDR_W  PC value for the next edge (combinational).
REQ-020 CUR_INS  output  INS_W  word at PC_OUT (combinational).
REQ-021 IF_ID_PC4  output  ADDR_W  registered PC+PC_STEP of fetched word.
REQ-022 IF_ID_INS  output  INS_W  registered fetched instruction.
REQ-023 IF_ID_VALID  output  1  IF/ID holds a real instruction.
REQ-024 ADR_ERR  output  1  registered: fetched PC misaligned or beyond IMEM_DEPTH.

Function
REQ-025 Word index SHALL be address bits [log2(IMEM_DEPTH)+1:2]; bits [1:0] nonzero = misaligned.
REQ-026 CUR_INS SHALL be the memory word at PC_OUT, read asynchronously; 0 (NOP) when PC_OUT misaligned or >= 4*IMEM_DEPTH.
REQ-027 NEXT_INS_ADR priority SHALL be: BRANCH_TAKEN -> BRANCH_TARGET; else JUMP_TAKEN -> JUMP_TARGET; else STALL -> PC_OUT; else PC_OUT+PC_STEP.
REQ-028 PC+PC_STEP SHALL wrap modulo 2^ADDR_W with no error.
REQ-029 PC_OUT SHALL load NEXT_INS_ADR on every rising edge; a redirect overrides STALL.
REQ-030 IF/ID update priority SHALL be: FLUSH or any redirect -> IF_ID_VALID=0, IF_ID_INS=0, IF_ID_PC4 unchanged; else STALL -> hold all; else load CUR_INS, PC_OUT+PC_STEP, VALID=1.
REQ-031 ADR_ERR SHALL load the REQ-026 error condition whenever IF/ID loads, and clear when IF/ID is squashed.
REQ-032 MEM_WRITE SHALL write WR_DATA at the rising edge; misaligned or out-of-range WR_ADR writes SHALL be ignored.
REQ-033 A write to the word currently at PC_OUT SHALL not affect that cycle's CUR_INS; the new value is visible from the next cycle.
REQ-034 Latency: instruction at PC_OUT SHALL appear on IF_ID_INS one edge later (absent stall/flush).

Reset
REQ-035 RESET high SHALL immediately force PC_OUT=RESET_PC, IF_ID_INS=0, IF_ID_PC4=0, IF_ID_VALID=0, ADR_ERR=0, regardless of CLK.
REQ-036 Memory contents SHALL NOT be affected by RESET.
REQ-037 First edge after RESET release SHALL fetch from RESET_PC.

Verification
REQ-038 Preload words 0..3 = 0x11,0x22,0x33,0x44, release reset -> IF_ID_INS 0x11,0x22,0x33 on successive edges, IF_ID_PC4 4,8,12.
REQ-039 PC=8, STALL=1 two cycles -> PC_OUT stays 8, IF_ID contents held; STALL=0 -> PC_OUT 12.
REQ-040 PC=4, BRANCH_TAKEN=1 target 40 with JUMP_TAKEN=1 target 80 and STALL=1 -> PC_OUT=40, IF_ID_VALID=0 next edge.
REQ-041 JUMP_TARGET=0x402 -> CUR_INS=0, ADR_ERR=1 after next edge; PC=4*IMEM_DEPTH likewise.
REQ-042 PC=0xFFFFFFFC, no redirect -> PC_OUT wraps to 0, no ADR_ERR from wrap itself.
REQ-043 Assert RESET mid-fetch between edges -> outputs reach reset values before next edge; memory still holds 0x11 at word 0.
